// File: rtl/pn_activity_monitor.sv
// Receive-side activity checker: counts pn_in transitions over fixed windows,
// flags stuck windows and raises a sticky alarm after a run of them.
module pn_activity_monitor #(
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned MIN_TOGGLES   = 1,
  parameter int unsigned STUCK_LIMIT   = 4
) (
  input  logic             dut_clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear_alarm,
  input  logic             pn_in,
  output logic [CNT_W-1:0] toggle_count,
  output logic             count_valid,
  output logic             window_stuck,
  output logic             stuck_alarm,
  output logic             busy
);

  localparam int unsigned WC_W  = $clog2(WINDOW_CYCLES);
  localparam int unsigned RUN_W = $clog2(STUCK_LIMIT + 1);
  localparam int unsigned CMP_W = (CNT_W > 32) ? CNT_W : 32;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [WC_W-1:0]  WC_LAST   = WC_W'(WINDOW_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(STUCK_LIMIT);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, REPORT} state_t;

  state_t           state;
  logic             s1;
  logic             s2;
  logic [WC_W-1:0]  wcnt;
  logic [CNT_W-1:0] acc;
  logic [RUN_W-1:0] stuck_run;

  logic             toggle;
  logic [CNT_W-1:0] acc_next;
  logic             final_stuck;
  logic [RUN_W-1:0] run_next;

  // Window arithmetic for the current MEASURE cycle
  always_comb begin
    toggle      = s1 ^ s2;
    acc_next    = (acc == CNT_MAX) ? acc : acc + CNT_W'(toggle);
    final_stuck = CMP_W'(acc_next) < CMP_W'(MIN_TOGGLES);
    run_next    = '0;
    if (final_stuck) begin
      run_next = (stuck_run == RUN_LIMIT) ? stuck_run : stuck_run + RUN_W'(1);
    end
  end

  // Control FSM with registered outputs; a report-cycle update overrides clear_alarm
  always_ff @(posedge dut_clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      s1           <= 1'b0;
      s2           <= 1'b0;
      wcnt         <= '0;
      acc          <= '0;
      stuck_run    <= '0;
      toggle_count <= '0;
      count_valid  <= 1'b0;
      window_stuck <= 1'b0;
      stuck_alarm  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      s1          <= pn_in;
      s2          <= s1;
      count_valid <= 1'b0;
      if (clear_alarm) begin
        stuck_alarm <= 1'b0;
        stuck_run   <= '0;
      end
      case (state)
        IDLE: begin
          if (enable) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end
        ARM: begin
          wcnt  <= '0;
          acc   <= '0;
          state <= MEASURE;
        end
        MEASURE: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            wcnt <= wcnt + WC_W'(1);
            acc  <= acc_next;
            if (wcnt == WC_LAST) begin
              state        <= REPORT;
              toggle_count <= acc_next;
              window_stuck <= final_stuck;
              count_valid  <= 1'b1;
              stuck_run    <= run_next;
              if (run_next == RUN_LIMIT) begin
                stuck_alarm <= 1'b1;
              end
            end
          end
        end
        REPORT: begin
          if (enable) begin
            state <= ARM;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pn_activity_monitor.sv
// Scoreboard bench for pn_activity_monitor: two instances (normal and
// saturating count width), window-level reference model from pn history.
module tb_pn_activity_monitor;

  localparam int W0   = 16;
  localparam int CW0  = 16;
  localparam int W1   = 32;
  localparam int CW1  = 4;
  localparam int MINT = 1;
  localparam int LIM  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       clear_alarm;
  logic       pn_in;
  logic [1:0] en;

  logic [CW0-1:0] cnt0;
  logic           cv0, st0, al0, busy0;
  logic [CW1-1:0] cnt1;
  logic           cv1, st1, al1, busy1;

  pn_activity_monitor #(.WINDOW_CYCLES(W0), .CNT_W(CW0), .MIN_TOGGLES(MINT), .STUCK_LIMIT(LIM)) dut (
    .dut_clk(clk), .reset_n(reset_n), .enable(en[0]), .clear_alarm(clear_alarm), .pn_in(pn_in),
    .toggle_count(cnt0), .count_valid(cv0), .window_stuck(st0), .stuck_alarm(al0), .busy(busy0));

  pn_activity_monitor #(.WINDOW_CYCLES(W1), .CNT_W(CW1), .MIN_TOGGLES(MINT), .STUCK_LIMIT(LIM)) dut_sat (
    .dut_clk(clk), .reset_n(reset_n), .enable(en[1]), .clear_alarm(clear_alarm), .pn_in(pn_in),
    .toggle_count(cnt1), .count_valid(cv1), .window_stuck(st1), .stuck_alarm(al1), .busy(busy1));

  typedef struct {
    int edge_n;
    int cnt;
    bit stuck;
    bit alarm;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   nvec = 0;
  int   nbad = 0;
  int   ncyc = 0;
  bit   pn_hist [0:8191];
  int   mode = 0;
  int   m_run = 0;
  bit   m_alarm = 1'b0;

  // Edge numbering and the pn value each edge actually loads into the synchroniser
  always @(posedge clk) begin
    ncyc <= ncyc + 1;
    if (ncyc + 1 < 8192) pn_hist[ncyc+1] <= reset_n ? pn_in : 1'b0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    clear_alarm = 1'b0;
    case (mode)
      1: pn_in = ~pn_in;
      2: pn_in = 1'($urandom_range(0, 1));
      3: if ($urandom_range(0, 7) == 0) pn_in = ~pn_in;
      default: ;
    endcase
  endtask

  // Transitions between consecutive loaded samples feeding measured edges a..a+w-1
  function automatic int win_count(input int a, input int w, input int cw);
    int c = 0;
    for (int i = 0; i < w; i++) begin
      if (pn_hist[a+i-1] != pn_hist[a+i-2]) c++;
    end
    if (c > (1 << cw) - 1) c = (1 << cw) - 1;
    return c;
  endfunction

  task automatic start(input int which, output int t);
    en[which] = 1'b1;
    cycle();
    t = ncyc;
  endtask

  task automatic stop(input int which);
    cycle();
    en[which] = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic clear_idle();
    clear_alarm = 1'b1;
    cycle();
    m_run   = 0;
    m_alarm = 1'b0;
    check("alarm_after_clear", 64'(al0), 64'(0));
  endtask

  task automatic model_reset();
    m_run   = 0;
    m_alarm = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, 64'(cnt0), 64'(0));
    check({tag, "_valid"}, 64'(cv0), 64'(0));
    check({tag, "_stuck"}, 64'(st0), 64'(0));
    check({tag, "_alarm"}, 64'(al0), 64'(0));
    check({tag, "_busy"},  64'(busy0), 64'(0));
  endtask

  // Predict n back-to-back windows whose enable was first sampled at edge t
  task automatic run_windows(input int which, input int t, input int n, input bit clr_last, input bit rnd);
    int   w;
    int   cw;
    int   a;
    int   l;
    int   run_new;
    exp_t e;
    w  = (which != 0) ? W1 : W0;
    cw = (which != 0) ? CW1 : CW0;
    for (int k = 0; k < n; k++) begin
      a = t + 2 + k * (w + 2);
      l = a + w - 1;
      if (rnd) mode = int'($urandom_range(0, 3));
      while (ncyc < l - 1) cycle();
      e.edge_n = l;
      e.cnt    = win_count(a, w, cw);
      e.stuck  = (e.cnt < MINT);
      if (which == 0) begin
        run_new = e.stuck ? ((m_run + 1 > LIM) ? LIM : m_run + 1) : 0;
        if (clr_last && k == n - 1) begin
          clear_alarm = 1'b1;
          m_alarm     = 1'b0;
        end
        if (run_new == LIM) m_alarm = 1'b1;
        m_run   = run_new;
        e.alarm = m_alarm;
        q0.push_back(e);
      end else begin
        e.alarm = 1'b0;
        q1.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (cv0 === 1'b1) begin
      if (q0.size() == 0) begin
        nvec++;
        nbad++;
        $display("FAIL unexpected_report0: got count %0d expected no report (edge %0d)", cnt0, ncyc);
      end else begin
        e = q0.pop_front();
        check("report0_edge",  64'(ncyc), 64'(e.edge_n));
        check("report0_count", 64'(cnt0), 64'(e.cnt));
        check("report0_stuck", 64'(st0),  64'(e.stuck));
        check("report0_alarm", 64'(al0),  64'(e.alarm));
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (cv1 === 1'b1) begin
      if (q1.size() == 0) begin
        nvec++;
        nbad++;
        $display("FAIL unexpected_report1: got count %0d expected no report (edge %0d)", cnt1, ncyc);
      end else begin
        e = q1.pop_front();
        check("report1_edge",  64'(ncyc), 64'(e.edge_n));
        check("report1_count", 64'(cnt1), 64'(e.cnt));
        check("report1_stuck", 64'(st1),  64'(e.stuck));
        check("report1_alarm", 64'(al1),  64'(e.alarm));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t;
    int a;
    reset_n     = 1'b0;
    en          = 2'b00;
    clear_alarm = 1'b0;
    pn_in       = 1'b0;
    repeat (3) cycle();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    cycle();

    // Constant line: stuck windows, alarm on the fourth, sticky on the fifth
    mode = 0;
    start(0, t);
    run_windows(0, t, 5, 1'b0, 1'b0);
    stop(0);
    clear_idle();
    start(0, t);
    run_windows(0, t, 4, 1'b0, 1'b0);
    stop(0);
    clear_idle();
    start(0, t);
    run_windows(0, t, 4, 1'b1, 1'b0);
    stop(0);
    check("alarm_kept_on_coincident_clear", 64'(al0), 64'(1));

    // Toggling every cycle from reset release
    mode    = 1;
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    model_reset();
    check_reset_outputs("reset2");
    start(0, t);
    run_windows(0, t, 3, 1'b0, 1'b0);
    stop(0);

    // Abort at MEASURE cycle 8, then a fresh window
    start(0, t);
    a = t + 2;
    check("busy_measuring", 64'(busy0), 64'(1));
    while (ncyc < a + 7) cycle();
    en[0] = 1'b0;
    cycle();
    check("abort_busy",  64'(busy0), 64'(0));
    check("abort_valid", 64'(cv0),   64'(0));
    check("abort_hold",  64'(cnt0),  64'(16));
    repeat (4) cycle();
    check("abort_idle_busy", 64'(busy0), 64'(0));
    start(0, t);
    run_windows(0, t, 1, 1'b0, 1'b0);
    stop(0);

    // Reset at MEASURE cycle 10 with enable held high
    start(0, t);
    a = t + 2;
    while (ncyc < a + 9) cycle();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    model_reset();
    check_reset_outputs("midreset");
    run_windows(0, ncyc + 1, 1, 1'b0, 1'b0);
    stop(0);

    // Saturating count width
    mode = 1;
    start(1, t);
    run_windows(1, t, 2, 1'b0, 1'b0);
    stop(1);

    // Randomized activity per window
    start(0, t);
    run_windows(0, t, 12, 1'b0, 1'b1);
    stop(0);

    repeat (5) cycle();
    check("q0_drained", 64'(q0.size()), 64'(0));
    check("q1_drained", 64'(q1.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
